clk_run_ctrl: RTL and testbench
===============================

// Module: clk_run_ctrl
// PURPOSE
//  Run/step/speed controller for the toy MIPS CPU core. Debounces the 4 board
//  keys and runs a run/pause/step/halt FSM. Emits a single-cycle clock-enable
//  cpu_en at one of 4 selectable rates. Replaces key-selected derived clocks,
//  so the whole core stays on the one board clock.
// PARAMETERS
//  DB_CYCLES  4    consecutive stable cycles before a key level is accepted (board: 20000)
//  DIV0       2    cpu_en period in clocks at speed 0
//  DIV1       4    cpu_en period at speed 1
//  DIV2       8    cpu_en period at speed 2
//  DIV3       16   cpu_en period at speed 3
//  CNT_W      32   width of the debounce and divider counters
// PORTS
//  clk       in   1  system clock; all logic on the rising edge
//  rst       in   1  asynchronous, active-low reset
//  key       in   4  raw keys, active high: [0] run/pause, [1] step, [2] speed+, [3] speed-
//  halt_req  in   1  CPU halt request (e.g. syscall exit); level, sampled each edge
//  cpu_en    out  1  registered one-cycle clock enable for the CPU datapath
//  state     out  2  FSM state: 0 PAUSE, 1 RUN, 2 STEP, 3 HALT
//  speed     out  2  current speed level 0..3
// BEHAVIOUR
//  Reset: asserting rst clears everything immediately, also mid-run or mid-debounce.
//   state=PAUSE, speed=0, cpu_en=0, and all sync, debounce and divider state is 0.
//  Debounce, per key:
//   - 2-FF synchroniser output s2.
//   - Counter increments each edge while s2 != db and clears when s2 == db.
//   - When the counter == DB_CYCLES-1 and s2 != db, db <= s2 and the counter clears.
//   - press = db & ~db_d, a one-cycle pulse on each accepted rising edge.
//   - Latency: state/speed change DB_CYCLES+2 edges after the first edge that samples the new key level.
//   - Glitches shorter than DB_CYCLES cycles produce no press.
//  Press arbitration: several presses in one cycle -> only the highest priority
//   is acted on (key0 > key1 > key2 > key3). The rest are dropped, not queued.
//  FSM transitions (halt_req outranks any key press in the same cycle):
//   PAUSE: press0 -> RUN; press1 -> STEP; halt_req -> HALT.
//   RUN:   press0 -> PAUSE; halt_req -> HALT.
//   STEP:  unconditionally -> PAUSE on the next edge, with cpu_en=1 for exactly
//          that one cycle. If halt_req is high instead -> HALT and cpu_en=0.
//   HALT:  cpu_en held 0. press0 with halt_req low -> PAUSE; all other presses ignored.
//  Speed: press2 -> speed+1, saturating at 3. press3 -> speed-1, saturating at 0.
//   Accepted in every state except HALT.
//   A speed change clears the divider so the new period starts cleanly.
//  Divider:
//   - cnt counts only in RUN: 0..DIVn-1, then wraps to 0.
//   - cnt is held at 0 in every other state and on entry to RUN.
//   - cpu_en <= (state==RUN && cnt==DIVn-1): a 1-cycle pulse every DIVn clocks.
//   - First pulse comes DIVn edges after RUN is entered.
//   - Leaving RUN (pause or halt) drops cpu_en at the same edge; no partial pulse is emitted.
//  DIVn >= 2 is required; DIVn == 1 is not supported.
// TESTING (DB_CYCLES=4, defaults)
//  1 Reset, then idle 20 clk -> state=0, speed=0, cpu_en=0 throughout.
//  2 key[0] held high 10 clk -> state=1 at edge +6. cpu_en then pulses every
//    2 clk; key[0] pressed again -> state=0 and cpu_en stays 0.
//  3 In PAUSE, key[1] pressed 3 times -> exactly 3 single-cycle cpu_en pulses,
//    state returns to 0 after each.
//  4 key[2] pressed 5 times -> speed goes 1,2,3,3,3; in RUN the cpu_en period is
//    16 clk. key[3] pressed once -> period 8 clk, measured from the change.
//  5 key[0] pulse of 2 clk (glitch) -> no state change. key[0]+key[2] pressed
//    together -> only RUN taken, speed unchanged.
//  6 halt_req=1 in RUN in the same cycle as press0 -> state=3, cpu_en=0.
//    Press0 with halt_req=1 -> stays 3. halt_req=0, press0 -> state=0.
//    rst pulsed low mid-RUN -> all outputs 0 at once, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl -- run/pause/step/halt and speed controller for the toy MIPS core.
//
// The four board keys are synchronised and debounced. A small FSM turns the
// accepted key presses into run, pause, single-step and speed-change actions.
// Instead of switching the CPU onto a derived clock, the block emits a
// one-cycle clock enable at one of four selectable rates, so the whole core
// stays on the single board clock.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-low reset
//   key      in   4  raw keys, active high: [0] run/pause, [1] step,
//                    [2] speed+, [3] speed-
//   halt_req in   1  CPU halt request (level)
//   cpu_en   out  1  registered one-cycle clock enable for the CPU datapath
//   state    out  2  0 PAUSE, 1 RUN, 2 STEP, 3 HALT
//   speed    out  2  current speed level 0..3 (period DIV0..DIV3)
module clk_run_ctrl #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DIV0      = 2,
  parameter int unsigned DIV1      = 4,
  parameter int unsigned DIV2      = 8,
  parameter int unsigned DIV3      = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       halt_req,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic [1:0] speed
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 32'd1);

  logic [3:0]            sync1_r;
  logic [3:0]            sync2_r;
  logic [3:0][CNT_W-1:0] db_cnt_r;
  logic [3:0]            db_r;
  logic [3:0]            db_dly_r;
  logic [3:0]            press_s;
  logic [3:0]            act_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [1:0]            speed_r;
  logic [1:0]            speed_nxt_s;
  logic                  speed_chg_s;
  logic [CNT_W-1:0]      div_cnt_r;
  logic [CNT_W-1:0]      div_cnt_nxt_s;
  logic [CNT_W-1:0]      div_last_s;
  logic                  stay_run_s;
  logic                  cpu_en_r;
  logic                  cpu_en_nxt_s;

  // Two-flop synchroniser for the asynchronous board keys.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Per-key debounce: a new level is accepted after DB_CYCLES consecutive
  // cycles of disagreement with the currently accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r <= '0;
      db_r     <= 4'b0000;
      db_dly_r <= 4'b0000;
    end else begin
      db_dly_r <= db_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_r[i]     <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  assign press_s = db_r & ~db_dly_r;

  // Fixed-priority pick of a single press; lower key index wins, others drop.
  always_comb begin
    act_s = 4'b0000;
    if (press_s[0]) begin
      act_s = 4'b0001;
    end else if (press_s[1]) begin
      act_s = 4'b0010;
    end else if (press_s[2]) begin
      act_s = 4'b0100;
    end else if (press_s[3]) begin
      act_s = 4'b1000;
    end else begin
      act_s = 4'b0000;
    end
  end

  // Terminal count of the divider for the current speed.
  always_comb begin
    div_last_s = CNT_W'(DIV3 - 32'd1);
    case (speed_r)
      2'd0:    div_last_s = CNT_W'(DIV0 - 32'd1);
      2'd1:    div_last_s = CNT_W'(DIV1 - 32'd1);
      2'd2:    div_last_s = CNT_W'(DIV2 - 32'd1);
      default: div_last_s = CNT_W'(DIV3 - 32'd1);
    endcase
  end

  // Next state, next speed, divider and clock-enable decisions.
  always_comb begin
    state_nxt_s = state_r;
    speed_nxt_s = speed_r;
    case (state_r)
      ST_PAUSE: begin
        if (halt_req)      state_nxt_s = ST_HALT;
        else if (act_s[0]) state_nxt_s = ST_RUN;
        else if (act_s[1]) state_nxt_s = ST_STEP;
        else               state_nxt_s = ST_PAUSE;
      end
      ST_RUN: begin
        if (halt_req)      state_nxt_s = ST_HALT;
        else if (act_s[0]) state_nxt_s = ST_PAUSE;
        else               state_nxt_s = ST_RUN;
      end
      ST_STEP: begin
        if (halt_req)      state_nxt_s = ST_HALT;
        else               state_nxt_s = ST_PAUSE;
      end
      ST_HALT: begin
        if (act_s[0] && !halt_req) state_nxt_s = ST_PAUSE;
        else                       state_nxt_s = ST_HALT;
      end
      default: state_nxt_s = ST_PAUSE;
    endcase

    // halt_req outranks every key, including the speed keys.
    if (state_r != ST_HALT && !halt_req) begin
      if (act_s[2] && speed_r != 2'd3) begin
        speed_nxt_s = speed_r + 2'd1;
      end else if (act_s[3] && speed_r != 2'd0) begin
        speed_nxt_s = speed_r - 2'd1;
      end else begin
        speed_nxt_s = speed_r;
      end
    end else begin
      speed_nxt_s = speed_r;
    end

    speed_chg_s = (speed_nxt_s != speed_r);
    // A speed change restarts the period, so the divider counts only while
    // RUN continues with an unchanged speed.
    stay_run_s  = (state_r == ST_RUN) && (state_nxt_s == ST_RUN) && !speed_chg_s;

    if (stay_run_s) begin
      if (div_cnt_r == div_last_s) div_cnt_nxt_s = '0;
      else                         div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
    end else begin
      div_cnt_nxt_s = '0;
    end

    cpu_en_nxt_s = (stay_run_s && (div_cnt_r == div_last_s)) ||
                   ((state_r == ST_STEP) && (state_nxt_s == ST_PAUSE));
  end

  // State, speed, divider and enable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_PAUSE;
      speed_r   <= 2'd0;
      div_cnt_r <= '0;
      cpu_en_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      speed_r   <= speed_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      cpu_en_r  <= cpu_en_nxt_s;
    end
  end

  assign state  = state_r;
  assign speed  = speed_r;
  assign cpu_en = cpu_en_r;

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Testbench for clk_run_ctrl (DB_CYCLES=4, default dividers).
// A driver issues key/halt stimulus each cycle and pushes the reference
// model's predicted outputs into a queue; an independent monitor pops and
// compares one expectation after every rising edge.
module tb_clk_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key = 4'b0000;
  logic       halt_req = 1'b0;
  logic       cpu_en;
  logic [1:0] state;
  logic [1:0] speed;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] spd;
    logic       en;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state (behavioural, not cycle-structured like the RTL)
  logic [3:0] m_samp[$];   // key level sampled at each clock edge
  logic [3:0] m_db;        // accepted key levels
  logic [3:0] m_db_d;      // accepted levels one edge earlier
  int         m_state;
  int         m_speed;
  int         m_age;       // edges spent in RUN since entry or speed change
  logic       m_en;

  clk_run_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .state    (state),
    .speed    (speed)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_samp.delete();
    for (int i = 0; i < 6; i++) m_samp.push_back(4'b0000);
    m_db    = 4'b0000;
    m_db_d  = 4'b0000;
    m_state = 0;
    m_speed = 0;
    m_age   = 0;
    m_en    = 1'b0;
  endfunction

  // Advance the model across one rising edge with inputs k/h, push expectation.
  function automatic void model_step(input logic [3:0] k, input logic h);
    logic [3:0] press;
    logic [3:0] new_db;
    logic [3:0] s;
    int pick, nstate, nspeed, n;
    bit all_diff;
    press  = m_db & ~m_db_d;
    pick   = -1;
    for (int i = 3; i >= 0; i--) if (press[i]) pick = i;
    nstate = m_state;
    nspeed = m_speed;
    if (h) begin
      nstate = 3;
    end else begin
      case (m_state)
        0: if (pick == 0) nstate = 1; else if (pick == 1) nstate = 2;
        1: if (pick == 0) nstate = 0;
        2: nstate = 0;
        default: if (pick == 0) nstate = 0;
      endcase
      if (m_state != 3) begin
        if (pick == 2) nspeed = (m_speed < 3) ? m_speed + 1 : 3;
        else if (pick == 3) nspeed = (m_speed > 0) ? m_speed - 1 : 0;
      end
    end
    if (m_state == 1 && nstate == 1 && nspeed == m_speed) begin
      m_age = m_age + 1;
      m_en  = ((m_age % (2 << m_speed)) == 0);
    end else begin
      m_age = 0;
      m_en  = (m_state == 2 && nstate == 0);
    end
    // A key level is accepted once four consecutive samples, taken two
    // to five edges ago, all disagree with the accepted level.
    m_samp.push_back(k);
    n = m_samp.size();
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = 3; j <= 6; j++) begin
        s = m_samp[n - j];
        if (s[i] == m_db[i]) all_diff = 1'b0;
      end
      new_db[i] = all_diff ? ~m_db[i] : m_db[i];
    end
    m_db_d = m_db;
    m_db   = new_db;
    if (m_samp.size() > 8) void'(m_samp.pop_front());
    m_state = nstate;
    m_speed = nspeed;
    exp_q.push_back({2'(m_state), 2'(m_speed), m_en});
  endfunction

  // Monitor: one DUT output sample per rising edge, compared to the scoreboard.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if ({state, speed, cpu_en} !== mon_e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got state=%0d speed=%0d cpu_en=%0b, want state=%0d speed=%0d cpu_en=%0b",
                 $time, state, speed, cpu_en, mon_e.st, mon_e.spd, mon_e.en);
      end
    end
  end

  task automatic cyc(input logic [3:0] k, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key      = k;
      halt_req = h;
      model_step(k, h);
    end
  endtask

  task automatic press_key(input logic [3:0] k);
    cyc(k, 1'b0, 7);
    cyc(4'b0000, 1'b0, 7);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b1;
    key      = 4'b0000;
    halt_req = 1'b0;
    model_reset();
    model_step(4'b0000, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({state, speed, cpu_en} !== 5'b00000) begin
      miscompares++;
      $display("FAIL %s: got state=%0d speed=%0d cpu_en=%0b, want all 0",
               tag, state, speed, cpu_en);
    end
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    release_reset();
  endtask

  initial begin
    int r, hold;
    logic [3:0] k;
    logic h;
    model_reset();
    #12;
    check_reset_outputs("reset_state");
    release_reset();

    // Idle after reset
    cyc(4'b0000, 1'b0, 20);
    // Run at speed 0, then pause
    cyc(4'b0001, 1'b0, 10);
    cyc(4'b0000, 1'b0, 20);
    press_key(4'b0001);
    cyc(4'b0000, 1'b0, 10);
    // Three single steps
    for (int i = 0; i < 3; i++) press_key(4'b0010);
    // Speed up five times (saturates), run, slow down once, pause
    for (int i = 0; i < 5; i++) press_key(4'b0100);
    press_key(4'b0001);
    cyc(4'b0000, 1'b0, 40);
    press_key(4'b1000);
    cyc(4'b0000, 1'b0, 30);
    press_key(4'b0001);
    // Glitch, then simultaneous run + speed+
    cyc(4'b0001, 1'b0, 2);
    cyc(4'b0000, 1'b0, 10);
    press_key(4'b0101);
    cyc(4'b0000, 1'b0, 10);
    // halt_req on the same edge that press0 reaches the FSM
    cyc(4'b0001, 1'b0, 6);
    cyc(4'b0001, 1'b1, 1);
    cyc(4'b0000, 1'b1, 8);
    cyc(4'b0001, 1'b1, 7);
    cyc(4'b0000, 1'b1, 7);
    cyc(4'b0000, 1'b0, 2);
    press_key(4'b0001);
    // Back to RUN, then reset mid-run
    press_key(4'b0001);
    cyc(4'b0000, 1'b0, 5);
    async_reset_check();
    cyc(4'b0000, 1'b0, 5);

    // Randomised segments
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 15);
      if (r < 8) begin
        k    = 4'b0001 << $urandom_range(0, 3);
        hold = $urandom_range(4, 10);
      end else if (r < 10) begin
        k    = 4'b0001 << $urandom_range(0, 3);
        hold = $urandom_range(1, 3);
      end else if (r < 12) begin
        k    = 4'($urandom_range(0, 15));
        hold = $urandom_range(4, 10);
      end else begin
        k    = 4'b0000;
        hold = $urandom_range(1, 10);
      end
      h = ($urandom_range(0, 11) == 0);
      cyc(k, h, hold);
      cyc(4'b0000, 1'b0, $urandom_range(4, 24));
      if ($urandom_range(0, 63) == 0) async_reset_check();
    end

    cyc(4'b0000, 1'b0, 3);
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
